// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the parameterised UART receiver: FSM states, parity
// mode encodings and parameter legality checks.
package uart_rx_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_HIGH
  } rx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic bit data_bits_ok(input int n);
    return (n >= 5) && (n <= 9);
  endfunction

  function automatic bit oversample_ok(input int n);
    return (n >= 8) && (n <= 64) && ((n % 2) == 0);
  endfunction

  function automatic bit parity_mode_ok(input int n);
    return (n == PARITY_NONE) || (n == PARITY_EVEN) || (n == PARITY_ODD);
  endfunction

  function automatic bit stop_bits_ok(input int n);
    return (n == 1) || (n == 2);
  endfunction

endpackage

// File: rtl/uart_rx_param_bit_sampler.sv
// Line synchroniser, per-bit tick counter and 3-sample majority vote around
// the middle of each bit period.
module uart_bit_sampler #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sample_tick,
  input  logic rx_async,
  input  logic cnt_clr,
  output logic rxs,
  output logic rxs_prev,
  output logic bit_done,
  output logic bit_val
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] MID_LO  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] MID     = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] MID_HI  = CNT_W'(OVERSAMPLE / 2 + 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             prev_q, prev_d;
  logic             s_lo_q, s_lo_d;
  logic             s_mid_q, s_mid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] idx;

  always_comb begin
    sync1_d = rx_async;
    sync2_d = sync1_q;
    prev_d  = prev_q;
    s_lo_d  = s_lo_q;
    s_mid_d = s_mid_q;
    cnt_d   = cnt_q;
    idx     = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
    // The tick that detects the start edge is tick 0 of the start bit.
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (sample_tick) begin
      cnt_d = idx;
      if (idx == MID_LO) s_lo_d  = sync2_q;
      if (idx == MID)    s_mid_d = sync2_q;
    end
    if (sample_tick) prev_d = sync2_q;
  end

  assign rxs      = sync2_q;
  assign rxs_prev = prev_q;
  assign bit_done = sample_tick && !cnt_clr && (idx == MID_HI);
  assign bit_val  = (s_lo_q & s_mid_q) | (s_lo_q & sync2_q) | (s_mid_q & sync2_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
      s_lo_q  <= 1'b0;
      s_mid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      s_lo_q  <= s_lo_d;
      s_mid_q <= s_mid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Oversampling UART receiver with configurable frame format, a valid/ready
// output holding register and a sticky overrun flag.
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_tick,
  input  logic                 UART_RX,
  output logic [DATA_BITS-1:0] RX_DATA,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  if (!(data_bits_ok(DATA_BITS) && oversample_ok(OVERSAMPLE) &&
        parity_mode_ok(PARITY_MODE) && stop_bits_ok(STOP_BITS))) begin : g_bad_params
    $error("uart_rx_param: illegal parameter combination");
  end

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 ferr_acc_q, ferr_acc_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 perr_q, perr_d;
  logic                 ferr_q, ferr_d;
  logic                 overrun_q, overrun_d;

  logic rxs, rxs_prev, bit_done, bit_val;
  logic commit, accept, frame_ferr, frame_perr;

  uart_bit_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clk        (clk),
    .reset      (reset),
    .sample_tick(sample_tick),
    .rx_async   (UART_RX),
    .cnt_clr    ((state_q == ST_IDLE) || (state_q == ST_WAIT_HIGH)),
    .rxs        (rxs),
    .rxs_prev   (rxs_prev),
    .bit_done   (bit_done),
    .bit_val    (bit_val)
  );

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    ferr_acc_d = ferr_acc_q;
    commit     = 1'b0;
    case (state_q)
      ST_IDLE: if (sample_tick && !rxs && rxs_prev) state_d = ST_START;
      ST_START: if (bit_done) begin
        if (bit_val) begin
          state_d = ST_IDLE;
        end else begin
          state_d    = ST_DATA;
          bit_cnt_d  = '0;
          par_d      = 1'b0;
          ferr_acc_d = 1'b0;
        end
      end
      ST_DATA: if (bit_done) begin
        shreg_d = {bit_val, shreg_q[DATA_BITS-1:1]};
        par_d   = par_q ^ bit_val;
        if (bit_cnt_q == LAST_DATA) begin
          bit_cnt_d = '0;
          state_d   = (PARITY_MODE == PARITY_NONE) ? ST_STOP : ST_PARITY;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      ST_PARITY: if (bit_done) begin
        par_d   = par_q ^ bit_val;
        state_d = ST_STOP;
      end
      ST_STOP: if (bit_done) begin
        ferr_acc_d = ferr_acc_q | ~bit_val;
        if (bit_cnt_q == LAST_STOP) begin
          commit  = 1'b1;
          // A line still low after the last stop bit must rise before a new frame.
          state_d = rxs ? ST_IDLE : ST_WAIT_HIGH;
        end else begin
          bit_cnt_d = bit_cnt_q + 4'd1;
        end
      end
      ST_WAIT_HIGH: if (sample_tick && rxs) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    accept     = rx_valid_q & rx_ready;
    frame_ferr = ferr_acc_q | ~bit_val;
    frame_perr = (PARITY_MODE == PARITY_NONE) ? 1'b0 : (par_q ^ (PARITY_MODE == PARITY_ODD));
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    overrun_d  = overrun_q;
    if (commit && (!rx_valid_q || accept)) begin
      rx_data_d  = shreg_q;
      perr_d     = frame_perr;
      ferr_d     = frame_ferr;
      rx_valid_d = 1'b1;
    end else if (accept) begin
      rx_valid_d = 1'b0;
    end
    if (accept) overrun_d = 1'b0;
    if (commit && rx_valid_q && !accept) overrun_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      ferr_acc_q <= 1'b0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      ferr_acc_q <= ferr_acc_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      overrun_q  <= overrun_d;
    end
  end

  assign RX_DATA    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed and randomised bench for uart_rx_param: an 8N1 receiver and a
// 7-bit even-parity receiver driven from bit-level serial stimulus.
module tb_uart_rx_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, sample_tick;
  logic       rx0, rdy0, v0, pe0, fe0, ov0, b0;
  logic [7:0] d0;
  logic       rx1, rdy1, v1, pe1, fe1, ov1, b1;
  logic [6:0] d1;

  uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_MODE(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .UART_RX(rx0),
    .RX_DATA(d0), .rx_valid(v0), .rx_ready(rdy0), .parity_err(pe0),
    .frame_err(fe0), .overrun(ov0), .busy(b0)
  );

  uart_rx_param #(.DATA_BITS(7), .OVERSAMPLE(16), .PARITY_MODE(1), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .UART_RX(rx1),
    .RX_DATA(d1), .rx_valid(v1), .rx_ready(rdy1), .parity_err(pe1),
    .frame_err(fe1), .overrun(ov1), .busy(b1)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int rise0_cyc = 0;
  int rises0 = 0;
  logic v0_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (v0 && !v0_prev) begin
      rises0 = rises0 + 1;
      rise0_cyc = cyc;
    end
    v0_prev = v0;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input int which, input logic v);
    if (which == 0) rx0 = v; else rx1 = v;
    tick(16);
  endtask

  // par_bit < 0 means no parity bit on the line.
  task automatic send(input int which, input logic [8:0] data, input int nbits,
                      input int par_bit, input logic stop_v);
    fall_cyc = cyc;
    drive(which, 1'b0);
    for (int i = 0; i < nbits; i++) drive(which, data[i]);
    if (par_bit >= 0) drive(which, par_bit[0]);
    drive(which, stop_v);
    if (which == 0) rx0 = 1'b1; else rx1 = 1'b1;
  endtask

  task automatic accept(input int which);
    if (which == 0) rdy0 = 1'b1; else rdy1 = 1'b1;
    tick(1);
    rdy0 = 1'b0;
    rdy1 = 1'b0;
  endtask

  initial begin
    logic [8:0] data;
    int lat, ones, par, r;
    logic bad_p, bad_s, exp_pe, exp_fe;

    reset = 1'b0; sample_tick = 1'b1;
    rx0 = 1'b1; rx1 = 1'b1; rdy0 = 1'b0; rdy1 = 1'b0;
    tick(3);
    chk("reset_valid0", 32'(v0), 0);
    chk("reset_data0", 32'(d0), 0);
    chk("reset_busy0", 32'(b0), 0);
    chk("reset_flags0", {29'd0, pe0, fe0, ov0}, 0);
    chk("reset_valid1", 32'(v1), 0);
    reset = 1'b1;
    tick(5);
    chk("idle_busy0", 32'(b0), 0);

    // 8N1 0x55 with latency from the line fall
    send(0, 9'h055, 8, -1, 1'b1);
    lat = rise0_cyc - fall_cyc;
    chk("latency_55", (lat >= 154 && lat <= 156) ? 155 : lat, 155);
    chk("data_55", 32'(d0), 'h55);
    chk("valid_55", 32'(v0), 1);
    chk("flags_55", {30'd0, pe0, fe0}, 0);
    accept(0);
    chk("accept_55", 32'(v0), 0);
    tick(16);

    // 7E1 0x41: wrong then correct parity bit
    send(1, 9'h041, 7, 1, 1'b1);
    chk("data_41_bad", 32'(d1), 'h41);
    chk("perr_41_bad", 32'(pe1), 1);
    accept(1);
    tick(16);
    send(1, 9'h041, 7, 0, 1'b1);
    chk("data_41_good", 32'(d1), 'h41);
    chk("perr_41_good", 32'(pe1), 0);
    accept(1);
    tick(16);

    // Random 7E1 frames with occasional bad parity or bad stop bit
    for (int f = 0; f < 8; f++) begin
      data  = 9'($urandom_range(0, 127));
      bad_p = ($urandom_range(0, 2) == 0);
      bad_s = ($urandom_range(0, 3) == 0);
      ones = 0;
      for (int k = 0; k < 7; k++) ones += int'(data[k]);
      par    = (ones % 2) ^ int'(bad_p);
      exp_pe = (((ones + par) % 2) != 0);
      exp_fe = bad_s;
      send(1, data, 7, par, ~bad_s);
      chk("rnd7_valid", 32'(v1), 1);
      chk("rnd7_data", 32'(d1), 32'(data[6:0]));
      chk("rnd7_perr", 32'(pe1), 32'(exp_pe));
      chk("rnd7_ferr", 32'(fe1), 32'(exp_fe));
      accept(1);
      tick(32);
    end

    // Random 8N1 bytes
    for (int f = 0; f < 6; f++) begin
      data = 9'($urandom_range(0, 255));
      send(0, data, 8, -1, 1'b1);
      chk("rnd8_data", 32'(d0), 32'(data[7:0]));
      chk("rnd8_ovr", 32'(ov0), 0);
      accept(0);
      tick(8);
    end

    // 5-clk low glitch on an idle line
    r = rises0;
    rx0 = 1'b0;
    tick(5);
    rx0 = 1'b1;
    tick(10);
    chk("glitch_busy", 32'(b0), 0);
    tick(40);
    chk("glitch_no_valid", rises0 - r, 0);

    // Two frames without acceptance
    send(0, 9'h0A5, 8, -1, 1'b1);
    send(0, 9'h03C, 8, -1, 1'b1);
    chk("ovr_data", 32'(d0), 'hA5);
    chk("ovr_valid", 32'(v0), 1);
    chk("ovr_flag", 32'(ov0), 1);
    accept(0);
    chk("ovr_accept_valid", 32'(v0), 0);
    chk("ovr_accept_flag", 32'(ov0), 0);
    tick(16);

    // Break: line low for 20 bit times
    r = rises0;
    rx0 = 1'b0;
    tick(320);
    chk("brk_frames", rises0 - r, 1);
    chk("brk_data", 32'(d0), 0);
    chk("brk_ferr", 32'(fe0), 1);
    chk("brk_busy", 32'(b0), 1);
    rx0 = 1'b1;
    tick(8);
    chk("brk_busy_clear", 32'(b0), 0);
    accept(0);
    tick(16);
    send(0, 9'h081, 8, -1, 1'b1);
    chk("brk_next_data", 32'(d0), 'h81);
    chk("brk_next_ferr", 32'(fe0), 0);

    // Reset in the middle of the data bits of 0xFF, with 0x81 still held
    drive(0, 1'b0);
    for (int i = 0; i < 4; i++) drive(0, 1'b1);
    rx0 = 1'b1;
    tick(5);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(v0), 0);
    chk("rst_mid_data", 32'(d0), 0);
    chk("rst_mid_busy", 32'(b0), 0);
    chk("rst_mid_flags", {29'd0, pe0, fe0, ov0}, 0);
    tick(2);
    reset = 1'b1;
    tick(80);
    chk("rst_after_valid", 32'(v0), 0);
    chk("rst_after_busy", 32'(b0), 0);
    send(0, 9'h012, 8, -1, 1'b1);
    chk("rst_next_data", 32'(d0), 'h12);
    chk("rst_next_valid", 32'(v0), 1);
    accept(0);
    tick(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
